// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage 16-bit CPU.
// Generates per-cycle stage enables, flushes and bubbles for load-use
// hazards, taken branches resolved in EX and multi-cycle multiplies held
// in EX. Also runs the halt/drain handshake used by the UART debug front-end.
module pipeline_hazard_ctrl #(
  parameter int unsigned MUL_LAT   = 3,  // cycles a multiply occupies EX (1..15)
  parameter int unsigned REG_AW    = 3,  // register address width
  parameter int unsigned DRAIN_CYC = 3   // bubble cycles to retire EX/MEM/WB
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        i_id_opcode,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_ex_valid,
  input  logic [3:0]        i_ex_opcode,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_taken,
  input  logic              i_halt_req,
  output logic              o_pc_en,
  output logic              o_pc_sel,
  output logic              o_ifid_en,
  output logic              o_ifid_flush,
  output logic              o_idex_en,
  output logic              o_idex_bubble,
  output logic              o_exmem_bubble,
  output logic              o_halt_ack,
  output logic [1:0]        o_state,
  output logic [15:0]       o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_e;

  // One shared down-counter serves both the multiply wait and the drain.
  localparam int unsigned CNT_W = 8;
  localparam bit             MUL_STALLS = (MUL_LAT > 1);
  localparam logic [CNT_W-1:0] MUL_LOAD   = MUL_STALLS ? CNT_W'(MUL_LAT - 2) : '0;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic             halt_ack_q, halt_ack_d;

  logic id_use_rs1, id_use_rs2, id_long_op;
  logic ex_load, ex_mul, ex_br, load_use;

  // Opcode decodes shared with the instruction decoder's encoding.
  always_comb begin
    id_use_rs1 = (i_id_opcode >= 4'd1) && (i_id_opcode <= 4'd10);
    id_use_rs2 = ((i_id_opcode >= 4'd2) && (i_id_opcode <= 4'd5)) || (i_id_opcode == 4'd10);
    // Multiplies and branches in ID must not be split from their EX follow-up by a halt.
    id_long_op = (i_id_opcode == 4'b0100) || (i_id_opcode == 4'b1000) ||
                 (i_id_opcode == 4'b1001) || (i_id_opcode == 4'b1010);
    ex_load    = i_ex_valid && (i_ex_opcode == 4'b0000);
    ex_mul     = i_ex_valid && ((i_ex_opcode == 4'b0100) || (i_ex_opcode == 4'b1000));
    ex_br      = i_ex_valid && ((i_ex_opcode == 4'b1001) || (i_ex_opcode == 4'b1010)) && i_ex_taken;
    load_use   = ex_load && ((id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                             (id_use_rs2 && (i_id_rs2 == i_ex_rd)));
  end

  // Next-state and per-cycle pipeline control outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    o_pc_en        = 1'b1;
    o_pc_sel       = 1'b0;
    o_ifid_en      = 1'b1;
    o_ifid_flush   = 1'b0;
    o_idex_en      = 1'b1;
    o_idex_bubble  = 1'b0;
    o_exmem_bubble = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (ex_br) begin
          o_pc_sel      = 1'b1;
          o_ifid_flush  = 1'b1;
          o_idex_bubble = 1'b1;
        end else if (MUL_STALLS && ex_mul) begin
          o_pc_en        = 1'b0;
          o_ifid_en      = 1'b0;
          o_idex_en      = 1'b0;
          o_exmem_bubble = 1'b1;
          cnt_d          = MUL_LOAD;
          state_d        = ST_MUL_WAIT;
        end else if (load_use) begin
          o_pc_en       = 1'b0;
          o_ifid_en     = 1'b0;
          o_idex_bubble = 1'b1;
        end else if (i_halt_req && !id_long_op) begin
          // This cycle still advances; draining starts next cycle.
          cnt_d   = DRAIN_LOAD;
          state_d = ST_DRAIN;
        end
      end
      ST_MUL_WAIT: begin
        if (cnt_q != '0) begin
          o_pc_en        = 1'b0;
          o_ifid_en      = 1'b0;
          o_idex_en      = 1'b0;
          o_exmem_bubble = 1'b1;
          cnt_d          = cnt_q - 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        o_pc_en       = 1'b0;
        o_ifid_en     = 1'b0;
        o_idex_bubble = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HALTED: begin
        o_pc_en       = 1'b0;
        o_ifid_en     = 1'b0;
        o_idex_bubble = 1'b1;
        if (!i_halt_req) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Reset holds the whole pipeline frozen and filled with NOPs.
    if (!rst_n) begin
      o_pc_en        = 1'b0;
      o_pc_sel       = 1'b0;
      o_ifid_en      = 1'b0;
      o_ifid_flush   = 1'b1;
      o_idex_en      = 1'b0;
      o_idex_bubble  = 1'b1;
      o_exmem_bubble = 1'b1;
    end
  end

  // Stall counter and halt acknowledge next values.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!o_pc_en && ((state_q == ST_RUN) || (state_q == ST_MUL_WAIT)) &&
        (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    halt_ack_d = (state_d == ST_HALTED);
  end

  // State, counters and acknowledge registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      halt_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      halt_ack_q  <= halt_ack_d;
    end
  end

  assign o_halt_ack  = halt_ack_q & rst_n;
  assign o_state     = state_q;
  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl. Two instances share stimulus:
// u_dut with MUL_LAT=3 and u_dut1 with MUL_LAT=1.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] id_op;
  logic [2:0] id_rs1, id_rs2, ex_rd;
  logic       ex_valid, ex_taken, halt_req;
  logic [3:0] ex_op;

  logic pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble, halt_ack;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic pc_en1, pc_sel1, ifid_en1, ifid_flush1, idex_en1, idex_bubble1, exmem_bubble1, halt_ack1;
  logic [1:0]  state1;
  logic [15:0] stall_cnt1;

  int checks = 0;
  int errors = 0;

  // Output packing: {pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble, halt_ack}
  localparam logic [7:0] P_RST = 8'b0001_0110;
  localparam logic [7:0] P_ADV = 8'b1010_1000;
  localparam logic [7:0] P_LU  = 8'b0000_1100;
  localparam logic [7:0] P_MUL = 8'b0000_0010;
  localparam logic [7:0] P_BR  = 8'b1111_1100;
  localparam logic [7:0] P_DRN = 8'b0000_1100;
  localparam logic [7:0] P_HLT = 8'b0000_1101;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MUL_LAT(3), .REG_AW(3), .DRAIN_CYC(3)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_id_opcode(id_op), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_ex_valid(ex_valid), .i_ex_opcode(ex_op), .i_ex_rd(ex_rd),
    .i_ex_taken(ex_taken), .i_halt_req(halt_req),
    .o_pc_en(pc_en), .o_pc_sel(pc_sel), .o_ifid_en(ifid_en), .o_ifid_flush(ifid_flush),
    .o_idex_en(idex_en), .o_idex_bubble(idex_bubble), .o_exmem_bubble(exmem_bubble),
    .o_halt_ack(halt_ack), .o_state(state), .o_stall_cnt(stall_cnt)
  );

  pipeline_hazard_ctrl #(.MUL_LAT(1), .REG_AW(3), .DRAIN_CYC(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_id_opcode(id_op), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_ex_valid(ex_valid), .i_ex_opcode(ex_op), .i_ex_rd(ex_rd),
    .i_ex_taken(ex_taken), .i_halt_req(halt_req),
    .o_pc_en(pc_en1), .o_pc_sel(pc_sel1), .o_ifid_en(ifid_en1), .o_ifid_flush(ifid_flush1),
    .o_idex_en(idex_en1), .o_idex_bubble(idex_bubble1), .o_exmem_bubble(exmem_bubble1),
    .o_halt_ack(halt_ack1), .o_state(state1), .o_stall_cnt(stall_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble, halt_ack};
  endfunction

  function automatic logic [7:0] outs1();
    return {pc_en1, pc_sel1, ifid_en1, ifid_flush1, idex_en1, idex_bubble1, exmem_bubble1, halt_ack1};
  endfunction

  task automatic drive(input logic [3:0] iop, input logic [2:0] r1, input logic [2:0] r2,
                       input logic ev, input logic [3:0] eop, input logic [2:0] erd,
                       input logic tk, input logic hr);
    id_op = iop; id_rs1 = r1; id_rs2 = r2;
    ex_valid = ev; ex_op = eop; ex_rd = erd; ex_taken = tk; halt_req = hr;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle, then compare pattern and state.
  task automatic cyc(input string tag, input logic [7:0] exp_p, input logic [1:0] exp_s);
    #3;
    check({tag, "_outs"}, 32'(outs()), 32'(exp_p));
    check({tag, "_state"}, 32'(state), 32'(exp_s));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'b1011, 3'd0, 3'd0, 1'b0, 4'b1011, 3'd0, 1'b0, 1'b0);
    step();
    cyc("reset", P_RST, 2'd0);
    check("reset_stall", 32'(stall_cnt), 32'd0);
    step();
    rst_n = 1'b1;

    // Idle, no hazards.
    cyc("idle", P_ADV, 2'd0);
    check("idle_stall", 32'(stall_cnt), 32'd0);
    step();

    // Load-use via rs2 of an ALU op: one stall cycle.
    drive(4'b0010, 3'd1, 3'd3, 1'b1, 4'b0000, 3'd3, 1'b0, 1'b0);
    cyc("lu_rs2", P_LU, 2'd0);
    step();
    drive(4'b0010, 3'd1, 3'd3, 1'b0, 4'b0000, 3'd3, 1'b0, 1'b0);
    cyc("lu_release", P_ADV, 2'd0);
    check("lu_stall1", 32'(stall_cnt), 32'd1);
    step();
    drive(4'b0001, 3'd3, 3'd1, 1'b1, 4'b0000, 3'd3, 1'b0, 1'b0);
    cyc("lu_rs1", P_LU, 2'd0);
    step();
    // Opcode 0001 does not read rs2.
    drive(4'b0001, 3'd1, 3'd3, 1'b1, 4'b0000, 3'd3, 1'b0, 1'b0);
    cyc("no_rs2_use", P_ADV, 2'd0);
    step();
    // LDA in ID reads nothing.
    drive(4'b0000, 3'd3, 3'd3, 1'b1, 4'b0000, 3'd3, 1'b0, 1'b0);
    cyc("id_lda", P_ADV, 2'd0);
    check("lu_stall2", 32'(stall_cnt), 32'd2);
    step();

    // Multiply 0100 held in EX: 2 stall cycles, release on the third.
    drive(4'b1011, 3'd0, 3'd0, 1'b1, 4'b0100, 3'd5, 1'b0, 1'b0);
    cyc("mul_c1", P_MUL, 2'd0);
    check("mul1_c1_outs", 32'(outs1()), 32'(P_ADV));
    step();
    cyc("mul_c2", P_MUL, 2'd1);
    check("mul1_c2_state", 32'(state1), 32'd0);
    step();
    cyc("mul_c3", P_ADV, 2'd1);
    step();
    drive(4'b1011, 3'd0, 3'd0, 1'b0, 4'b0100, 3'd5, 1'b0, 1'b0);
    cyc("mul_done", P_ADV, 2'd0);
    check("mul_stall", 32'(stall_cnt), 32'd4);
    check("mul1_stall", 32'(stall_cnt1), 32'd2);
    step();
    // Multiply 1000 follows the same pattern.
    drive(4'b1011, 3'd0, 3'd0, 1'b1, 4'b1000, 3'd5, 1'b0, 1'b0);
    cyc("imul_c1", P_MUL, 2'd0);
    step();
    cyc("imul_c2", P_MUL, 2'd1);
    step();
    cyc("imul_c3", P_ADV, 2'd1);
    step();

    // Taken branch with ID reading the EX rd: flush, no stall.
    drive(4'b0010, 3'd3, 3'd3, 1'b1, 4'b1001, 3'd3, 1'b1, 1'b0);
    cyc("br1001", P_BR, 2'd0);
    check("br_stall", 32'(stall_cnt), 32'd6);
    step();
    drive(4'b0010, 3'd3, 3'd3, 1'b1, 4'b1001, 3'd3, 1'b0, 1'b0);
    cyc("br_not_taken", P_ADV, 2'd0);
    step();
    drive(4'b0010, 3'd3, 3'd3, 1'b1, 4'b1010, 3'd3, 1'b1, 1'b0);
    cyc("br1010", P_BR, 2'd0);
    step();
    drive(4'b0010, 3'd3, 3'd3, 1'b0, 4'b1010, 3'd3, 1'b1, 1'b0);
    cyc("br_invalid", P_ADV, 2'd0);
    check("br_stall_after", 32'(stall_cnt), 32'd6);
    step();

    // Halt: blocked while ID holds a multiply.
    drive(4'b1000, 3'd0, 3'd0, 1'b0, 4'b1011, 3'd0, 1'b0, 1'b1);
    cyc("halt_blocked", P_ADV, 2'd0);
    step();
    drive(4'b1011, 3'd0, 3'd0, 1'b0, 4'b1011, 3'd0, 1'b0, 1'b1);
    cyc("halt_entry", P_ADV, 2'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("drain%0d", i), P_DRN, 2'd2);
      step();
    end
    cyc("halted", P_HLT, 2'd3);
    step();
    drive(4'b1011, 3'd0, 3'd0, 1'b0, 4'b1011, 3'd0, 1'b0, 1'b0);
    cyc("halted_drop", P_HLT, 2'd3);
    step();
    cyc("resume", P_ADV, 2'd0);
    check("halt_stall", 32'(stall_cnt), 32'd6);
    step();

    // Request dropped mid-drain: drain completes, one HALTED cycle, then RUN.
    drive(4'b1011, 3'd0, 3'd0, 1'b0, 4'b1011, 3'd0, 1'b0, 1'b1);
    cyc("drop_entry", P_ADV, 2'd0);
    step();
    drive(4'b1011, 3'd0, 3'd0, 1'b0, 4'b1011, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("drop_drain%0d", i), P_DRN, 2'd2);
      step();
    end
    cyc("drop_halted", P_HLT, 2'd3);
    step();
    cyc("drop_resume", P_ADV, 2'd0);
    step();

    // Reset in MUL_WAIT.
    drive(4'b1011, 3'd0, 3'd0, 1'b1, 4'b0100, 3'd5, 1'b0, 1'b0);
    cyc("rmul_c1", P_MUL, 2'd0);
    step();
    rst_n = 1'b0;
    drive(4'b1011, 3'd0, 3'd0, 1'b0, 4'b1011, 3'd0, 1'b0, 1'b0);
    cyc("rmul_in_reset", P_RST, 2'd1);
    step();
    rst_n = 1'b1;
    cyc("rmul_after", P_ADV, 2'd0);
    check("rmul_stall", 32'(stall_cnt), 32'd0);
    step();
    // Counter cleared: a new multiply gets the full stall.
    drive(4'b1011, 3'd0, 3'd0, 1'b1, 4'b0100, 3'd5, 1'b0, 1'b0);
    cyc("rmul2_c1", P_MUL, 2'd0);
    step();
    cyc("rmul2_c2", P_MUL, 2'd1);
    step();
    cyc("rmul2_c3", P_ADV, 2'd1);
    step();

    // Reset in DRAIN.
    drive(4'b1011, 3'd0, 3'd0, 1'b0, 4'b1011, 3'd0, 1'b0, 1'b1);
    cyc("rdrn_entry", P_ADV, 2'd0);
    step();
    cyc("rdrn_drain", P_DRN, 2'd2);
    rst_n = 1'b0;
    drive(4'b1011, 3'd0, 3'd0, 1'b0, 4'b1011, 3'd0, 1'b0, 1'b0);
    #1;
    check("rdrn_reset_outs", 32'(outs()), 32'(P_RST));
    step();
    rst_n = 1'b1;
    cyc("rdrn_after", P_ADV, 2'd0);
    check("rdrn_ack", 32'(halt_ack), 32'd0);
    check("rdrn_stall", 32'(stall_cnt), 32'd0);
    step();

    // Saturation: a held load-use stalls every cycle.
    drive(4'b0010, 3'd2, 3'd2, 1'b1, 4'b0000, 3'd2, 1'b0, 1'b0);
    repeat (65540) step();
    cyc("sat", P_LU, 2'd0);
    check("sat_cnt", 32'(stall_cnt), 32'h0000_FFFF);
    step();
    #3;
    check("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage 16-bit CPU pipeline (IF/ID/EX/MEM/WB).
- Produces per-cycle stage enables, flushes and bubbles for three cases:
  - load-use hazards;
  - taken branches resolved in EX;
  - multi-cycle multiplies held in EX.
- Also runs a halt/drain handshake so the UART debug front-end can stop the core cleanly.
- Sits beside the opcode decoder and consumes the same 4-bit opcode encoding.

Parameters:
- MUL_LAT, 3: cycles a multiply occupies EX. Legal range 1..15.
- REG_AW, 3: register address width.
- DRAIN_CYC, 3: bubble cycles needed to retire EX/MEM/WB before the halt is acknowledged.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- i_id_opcode  in  4  opcode in the ID stage.
- i_id_rs1  in  REG_AW  ID source register 1.
- i_id_rs2  in  REG_AW  ID source register 2.
- i_ex_valid  in  1  EX holds a real instruction, not a bubble.
- i_ex_opcode  in  4  opcode in EX.
- i_ex_rd  in  REG_AW  destination register of the EX instruction.
- i_ex_taken  in  1  EX branch condition is true. Only meaningful for opcodes 1001/1010.
- i_halt_req  in  1  halt request, level, held until acknowledged.
- o_pc_en  out  1  PC register update enable.
- o_pc_sel  out  1  1 = load branch target, 0 = PC+1.
- o_ifid_en  out  1  IF/ID register enable.
- o_ifid_flush  out  1  clear IF/ID.
- o_idex_en  out  1  ID/EX register enable.
- o_idex_bubble  out  1  load a NOP into ID/EX.
- o_exmem_bubble  out  1  load a NOP into EX/MEM.
- o_halt_ack  out  1  registered; core halted.
- o_state  out  2  FSM state: 0 RUN, 1 MUL_WAIT, 2 DRAIN, 3 HALTED.
- o_stall_cnt  out  16  hazard stall cycle counter.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- While rst_n=0, outputs are forced to:
  - pc_en=0, ifid_en=0, idex_en=0, pc_sel=0;
  - ifid_flush=1, idex_bubble=1, exmem_bubble=1;
  - halt_ack=0.
- Reset values: state=RUN, mul counter=0, o_stall_cnt=0, o_halt_ack=0.
- Reset mid-MUL_WAIT or mid-DRAIN aborts the operation; the next cycle is RUN.
- Decodes:
  - ex_load = i_ex_valid & i_ex_opcode==0000.
  - ex_mul = i_ex_valid & opcode in {0100, 1000}.
  - ex_br = i_ex_valid & opcode in {1001, 1010} & i_ex_taken.
  - ID uses rs1 for opcodes 0001..1010.
  - ID uses rs2 for opcodes 0010..0101 and 1010.
  - No register is special-cased. Opcodes 1011..1111 use no sources.
- Load-use: ex_load & (rs1 used & rs1==ex_rd | rs2 used & rs2==ex_rd).
- Default (RUN, no event): pc_en=1, ifid_en=1, idex_en=1, all flush/bubble signals 0.
- RUN priority, highest first:
  1. ex_br: pc_sel=1, pc_en=1, ifid_flush=1, idex_bubble=1. Overrides load-use.
  2. ex_mul with MUL_LAT>1: pc_en=0, ifid_en=0, idex_en=0, exmem_bubble=1. Counter is loaded with MUL_LAT-2. Next state is MUL_WAIT.
  3. Load-use: pc_en=0, ifid_en=0, idex_bubble=1. Exactly one cycle per occurrence.
  4. Halt entry: i_halt_req, none of the above, and i_id_opcode not in {0100, 1000, 1001, 1010}. This cycle advances normally; next state is DRAIN with the drain counter at DRAIN_CYC-1.
- MUL_WAIT:
  - Counter !=0: same stall pattern as RUN item 2; counter decrements.
  - Counter ==0: default advance; next state is RUN.
  - Total stall per multiply = MUL_LAT-1 cycles. MUL_LAT=1 never stalls.
- DRAIN: pc_en=0, ifid_en=0, idex_bubble=1. Counter decrements. When it reaches 0, next state is HALTED and o_halt_ack=1 from that cycle.
- HALTED:
  - Same outputs as DRAIN, plus halt_ack=1.
  - i_halt_req=0 returns to RUN the next cycle; halt_ack clears together with the state change.
- Halt request dropped during DRAIN: drain completes, HALTED is entered, then RUN follows one cycle later.
- o_stall_cnt: +1 in each cycle with pc_en=0 in RUN or MUL_WAIT. Saturates at 16'hFFFF. Not counted in DRAIN/HALTED.
- Combinational latency from inputs to enables is 0 cycles. The next-state decision lands in the next cycle.

Test Plan:
- Reset, then idle with non-hazard opcodes: pc_en=1, ifid_en=1, idex_en=1, flush/bubble=0, o_state=0, o_stall_cnt=0.
- EX LDA (0000) with rd=3 while ID CAL_add (0010) has rs2=3 → exactly 1 cycle of pc_en=0 and idex_bubble=1, then default. o_stall_cnt=1. Repeat with ID LDA (no sources): no stall.
- EX CAL_mul (0100) with MUL_LAT=3 → stall 2 cycles (o_state 0 then 1), exmem_bubble=1 in both, release on the 3rd. Rerun with MUL_LAT=1: no stall.
- EX BAF_immsub (1001) taken while a load-use condition is also true → pc_sel=1, ifid_flush=1, idex_bubble=1, pc_en=1, no stall, o_stall_cnt unchanged. With i_ex_taken=0: no flush.
- Halt request with ID IMM_mul → held in RUN. Next non-mul/branch ID → DRAIN for 3 cycles, o_halt_ack=1 on cycle 4. Dropping the request → RUN the next cycle, ack=0.
- Reset asserted in MUL_WAIT and in DRAIN → next cycle o_state=0, counters and ack cleared. Force 65536+ stall cycles → o_stall_cnt stays 16'hFFFF.
